// File: rtl/block_mux_nx1_reg.sv
// block_mux_nx1_reg: registered N:1 bus mux with direct or
// round-robin channel select and valid/ready on both sides.
module block_mux_nx1_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]       i_valid,
  output logic [NUM_CH-1:0]       o_ready,
  output logic [WIDTH-1:0]        o_data,
  output logic [SEL_W-1:0]        o_ch,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH-1);

  logic [SEL_W-1:0] rr_ptr;
  logic             load_en;
  logic             sel_ok;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_grant;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  assign load_en = !o_valid || i_ready;
  assign sel_ok  = {1'b0, i_sel} < NCH;

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin : rr_search
    logic [SEL_W:0] idx;
    idx      = '0;
    rr_hit   = 1'b0;
    rr_grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (idx >= NCH) idx = idx - NCH;
      if (i_valid[idx[SEL_W-1:0]]) begin
        rr_hit   = 1'b1;
        rr_grant = idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin : grant_sel
    grant_vld = 1'b0;
    grant     = '0;
    if (i_mode) begin
      grant_vld = rr_hit;
      grant     = rr_grant;
    end else begin
      grant_vld = sel_ok;
      grant     = i_sel;
    end
  end

  always_comb begin : ready_gen
    o_ready = '0;
    if (!i_rst && grant_vld && load_en)
      o_ready[grant] = 1'b1;
  end

  assign xfer = |(o_ready & i_valid);

  always_comb begin : data_sel
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == SEL_W'(k))
        grant_data = i_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= grant_data;
      o_ch    <= grant;
      if (i_mode)
        rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_mux_nx1_reg.sv
// tb_block_mux_nx1_reg: scoreboard bench for the registered N:1 mux,
// with a second 3-channel instance for out-of-range select and wrap.
`timescale 1ns/1ps
module tb_block_mux_nx1_reg;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] data;
  logic [N-1:0]  valid;
  logic [N-1:0]  ready_o;
  logic [W-1:0]  odata;
  logic [SW-1:0] och;
  logic          ovalid;
  logic          iready;

  logic          m3;
  logic [1:0]    s3;
  logic [23:0]   d3;
  logic [2:0]    v3;
  logic [2:0]    r3o;
  logic [W-1:0]  od3;
  logic [1:0]    oc3;
  logic          ov3;
  logic          ir3;

  block_mux_nx1_reg #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel),
    .i_data(data), .i_valid(valid), .o_ready(ready_o),
    .o_data(odata), .o_ch(och), .o_valid(ovalid), .i_ready(iready)
  );

  block_mux_nx1_reg #(.WIDTH(W), .NUM_CH(3), .SEL_W(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_mode(m3), .i_sel(s3),
    .i_data(d3), .i_valid(v3), .o_ready(r3o),
    .o_data(od3), .o_ch(oc3), .o_valid(ov3), .i_ready(ir3)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } word_t;

  word_t sb[$];
  int    m_rr;
  bit    m_full;

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] c0,
    input logic [W-1:0] c1, input logic [W-1:0] c2, input logic [W-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Reference model: grant from the selection rules, occupancy tracking.
  task automatic cycle(input bit md, input int s, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input bit rdy);
    int g;
    bit gv;
    bit ld;
    logic [N-1:0] exp_r;
    @(posedge clk);
    #2;
    mode = md; sel = s[SW-1:0]; valid = v; data = d; iready = rdy;
    #1;
    chk("o_valid", ovalid, m_full);
    ld = !m_full || rdy;
    gv = 0;
    g  = 0;
    if (!md) begin
      if (s < N) begin gv = 1; g = s; end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c = (m_rr + k) % N;
        if (!gv && v[c]) begin gv = 1; g = c; end
      end
    end
    exp_r = '0;
    if (gv && ld) exp_r[g] = 1'b1;
    chk("o_ready", ready_o, exp_r);
    if (gv && ld && v[g]) begin
      sb.push_back('{d[g*W +: W], SW'(g)});
      m_full = 1;
      if (md) m_rr = (g + 1) % N;
    end else if (rdy) begin
      m_full = 0;
    end
  endtask

  // Monitor: the front entry must be presented until it is consumed.
  always @(negedge clk) begin
    if (!rst && ovalid) begin
      if (sb.size() == 0) begin
        chk("sb_occupancy", sb.size(), 1);
      end else begin
        chk("sb o_data", odata, sb[0].d);
        chk("sb o_ch", och, sb[0].ch);
        if (iready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    mode = 1; sel = 0; valid = '1; data = '0; iready = 1;
    m3 = 0; s3 = 0; d3 = '0; v3 = '0; ir3 = 1;
    m_full = 0; m_rr = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst o_valid", ovalid, 0);
    chk("rst o_data", odata, 0);
    chk("rst o_ch", och, 0);
    chk("rst o_ready", ready_o, 0);
    chk("rst3 o_valid", ov3, 0);
    valid = '0;
    #1 rst = 0;

    // 3-channel instance: out-of-range select, then rr wrap
    m3 = 0; s3 = 3; v3 = 3'b111; d3 = {8'h33, 8'h22, 8'h11};
    cycle(0, 0, '0, '0, 1);
    chk("oor o_ready", r3o, 0);
    cycle(0, 0, '0, '0, 1);
    chk("oor o_valid", ov3, 0);
    s3 = 2; d3 = {8'h5C, 8'h22, 8'h11};
    cycle(0, 0, '0, '0, 1);
    chk("n3 o_ready", r3o, 3'b100);
    chk("n3 o_valid", ov3, 1);
    chk("n3 o_data", od3, 8'h5C);
    chk("n3 o_ch", oc3, 2);
    m3 = 1; v3 = 3'b010;
    #1 chk("n3 rr ready a", r3o, 3'b010);
    cycle(0, 0, '0, '0, 1);
    v3 = 3'b101;
    #1 chk("n3 rr ready b", r3o, 3'b100);
    cycle(0, 0, '0, '0, 1);
    v3 = 3'b011;
    #1 chk("n3 rr wrap ready", r3o, 3'b001);
    cycle(0, 0, '0, '0, 1);
    chk("n3 rr wrap o_ch", oc3, 0);
    chk("n3 rr wrap o_data", od3, 8'h11);
    v3 = '0; m3 = 0; s3 = 0;

    // direct select
    cycle(0, 2, 4'b0100, pack(8'h00, 8'h00, 8'hA5, 8'h00), 1);
    cycle(0, 2, 4'b0000, '0, 1);
    chk("t1 o_data", odata, 8'hA5);
    chk("t1 o_ch", och, 2);

    // backpressure
    cycle(0, 0, 4'b0001, pack(8'h11, 8'h00, 8'h00, 8'h00), 1);
    repeat (3) begin
      cycle(0, 1, 4'b0010, pack(8'h00, 8'h22, 8'h00, 8'h00), 0);
      chk("bp hold o_data", odata, 8'h11);
    end
    cycle(0, 1, 4'b0010, pack(8'h00, 8'h22, 8'h00, 8'h00), 1);
    cycle(0, 1, 4'b0000, '0, 1);
    chk("bp o_data", odata, 8'h22);
    chk("bp o_ch", och, 1);
    cycle(0, 1, 4'b0000, '0, 1);

    // round-robin fairness
    repeat (8) cycle(1, 0, 4'b1111, pack(8'h10, 8'h20, 8'h30, 8'h40), 1);
    cycle(1, 0, 4'b0000, '0, 1);

    // round-robin skip and wrap
    cycle(1, 0, 4'b0100, pack(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1);
    cycle(1, 0, 4'b0010, pack(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1);
    cycle(1, 0, 4'b1001, pack(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1);
    chk("skip o_ch", och, 1);
    cycle(1, 0, 4'b1001, pack(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1);
    chk("wrap o_ch", och, 3);
    cycle(1, 0, 4'b0000, '0, 1);
    chk("wrap2 o_ch", och, 0);

    // randomized traffic
    repeat (400) begin
      cycle(bit'($urandom % 2), int'($urandom % N), N'($urandom),
            (N*W)'($urandom), ($urandom % 4) != 0);
    end

    // async reset while a word is held
    cycle(1, 0, 4'b1111, pack(8'h61, 8'h62, 8'h63, 8'h64), 0);
    cycle(1, 0, 4'b1111, pack(8'h61, 8'h62, 8'h63, 8'h64), 0);
    chk("pre-rst o_valid", ovalid, 1);
    #3 rst = 1;
    #1;
    chk("arst o_valid", ovalid, 0);
    chk("arst o_data", odata, 0);
    chk("arst o_ch", och, 0);
    chk("arst o_ready", ready_o, 0);
    valid = '0;
    sb.delete();
    m_full = 0;
    m_rr = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 0;
    cycle(1, 0, 4'b1111, pack(8'h71, 8'h72, 8'h73, 8'h74), 1);
    cycle(1, 0, 4'b0000, '0, 1);
    chk("post-rst o_ch", och, 0);
    chk("post-rst o_data", odata, 8'h71);

    repeat (3) cycle(0, 0, '0, '0, 1);
    @(negedge clk);
    #1;
    chk("sb drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/block_mux_nx1_reg.md
Name: block_mux_nx1_reg

Overview:
- Parametrised, registered N:1 bus multiplexer; successor to the single-bit 2:1 gate-level mux in the CPU datapath.
- Selects one of NUM_CH WIDTH-bit input channels into a one-entry output register using valid/ready handshakes on both sides.
- Two select modes: direct (external select) and round-robin (internal fair arbitration).
- Used where several datapath sources (ALU, memory, immediate, PC) share one registered bus toward the register file.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal ceil(log2(NUM_CH)).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_mode  input  1  0 = direct select, 1 = round-robin.
- i_sel  input  SEL_W  channel index in direct mode; ignored in round-robin mode.
- i_data  input  NUM_CH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- i_valid  input  NUM_CH  per-channel valid.
- o_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- o_data  output  WIDTH  registered selected data.
- o_ch  output  SEL_W  index of the channel that produced o_data.
- o_valid  output  1  output register holds a valid word.
- i_ready  input  1  downstream accepts o_data.

Behaviour:
- Reset (async, immediate): o_valid=0, o_data=0, o_ch=0, round-robin pointer rr_ptr=0. o_ready is forced all-zero while i_rst is high.
- Load enable: load_en = !o_valid || i_ready. The output register accepts a new word only when it is empty or being drained in the same cycle, so one-word-per-cycle throughput is sustained.
- Grant, direct mode:
  - g = i_sel if i_sel < NUM_CH.
  - If i_sel >= NUM_CH, no channel is granted and all o_ready bits are 0.
  - o_ready[g] = load_en, independent of i_valid[g].
- Grant, round-robin mode:
  - g = first k with i_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH.
  - No valid channel means no grant and o_ready = 0.
  - o_ready[g] = load_en.
- Transfer: an input transfer occurs when i_valid[g] && o_ready[g]. At the next edge, o_data <= channel g data, o_ch <= g, o_valid <= 1.
- Transfer side effects:
  - In round-robin mode, rr_ptr <= (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - rr_ptr does not change in direct mode or when no transfer occurs.
- Drain: if o_valid && i_ready and no input transfer occurs, o_valid <= 0. o_data and o_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge; o_valid stays 1 with no bubble.
- Stall: if o_valid && !i_ready, then o_ready = 0 and o_data, o_ch, o_valid hold stable. Holding stable is mandatory.
- Latency: exactly 1 cycle from an accepted input to o_valid/o_data.
- Combinational paths: i_ready, i_mode, i_sel and (in round-robin mode) i_valid drive o_ready combinationally. No combinational path exists from any input to o_data, o_ch or o_valid.
- Mode switch: sampled every cycle and takes effect for that cycle's grant. rr_ptr is preserved across mode changes.
- Reset mid-operation: a pending output word is discarded and the block returns to the reset state. The first grant after reset release in round-robin mode starts its search at channel 0.

Test Plan:
- Reset, then direct mode with WIDTH=8, NUM_CH=4, i_sel=2, i_data ch2=0xA5, i_valid=4'b0100, i_ready=1 → o_ready=4'b0100; next cycle o_data=0xA5, o_ch=2, o_valid=1.
- Backpressure: output holds 0x11 from ch0 with i_ready=0 while ch1 is valid with 0x22 → o_ready=0 and output holds 0x11 for 3 cycles. Raise i_ready → next cycle o_data=0x22 with no bubble and no duplicate.
- Round-robin fairness: i_mode=1, all four channels valid (0x10, 0x20, 0x30, 0x40), i_ready=1 for 8 cycles → o_ch sequence 0,1,2,3,0,1,2,3 with the matching data values.
- Round-robin skip and wrap: rr_ptr=3 and only ch1 valid → ch1 granted, rr_ptr becomes 2. Then only ch0 and ch3 valid → ch3 granted, then ch0.
- Out-of-range select: direct mode with NUM_CH=3 and i_sel=3, all channels valid → o_ready=0 and o_valid stays 0.
- Async reset mid-stream: assert i_rst between clock edges while o_valid=1 → o_valid=0, o_data=0, o_ch=0 immediately, without waiting for an edge. After release in round-robin mode with all channels valid, the first o_ch=0.
